// File: rtl/mgia_line_fetch.sv
// mgia_line_fetch: prefetches one scanline per horizontal blank into a ping-pong line buffer for the MGIA shifter.
// Define MGIA_UNDERRUN_EN to add UNDERRUN_O, a sticky flag for lines whose fetch was cut short by the next LINE_I.
//
// state | meaning
// IDLE  | bus released, waiting for the next horizontal blank
// FETCH | bus master, copying words of the next line into the fill bank
module mgia_line_fetch #(
   parameter int WORDS_PER_LINE = 40,
   parameter int AW             = 23
) (
   input  logic          CLK_I_25MHZ,
   input  logic          RST_N_I,
   input  logic          VSYNC_I,
   input  logic          LINE_I,
   input  logic          FETCH_EN_I,
   input  logic [AW-1:0] FB_BASE_I,
   output logic [AW-1:0] MGIA_ADR_O,
   output logic          MGIA_CYC_O,
   output logic          MGIA_STB_O,
   input  logic          MGIA_ACK_I,
   input  logic [15:0]   MGIA_DAT_I,
   input  logic [5:0]    F_ADR_I,
   output logic [15:0]   F_DAT_O
`ifdef MGIA_UNDERRUN_EN
   ,
   output logic          UNDERRUN_O
`endif
);

   typedef enum logic {IDLE, FETCH} state_t;

   localparam logic [AW-1:0] LINE_STRIDE = AW'(WORDS_PER_LINE);
   localparam logic [AW-1:0] PTR_ONE     = AW'(1);
   localparam logic [5:0]    LAST_IDX    = 6'(WORDS_PER_LINE - 1);

   state_t        state, state_nxt;
   logic [AW-1:0] line_base, line_base_nxt;
   logic [AW-1:0] ptr, ptr_nxt;
   logic [5:0]    idx, idx_nxt;
   logic          disp_bank, disp_bank_nxt;
   logic          wr_en;
   logic [15:0]   line_mem [0:127];

   // Priority: ACK, then abort, then VSYNC reload, then a new fetch starting from the resulting ptr.
   always_comb begin
      state_nxt     = state;
      line_base_nxt = line_base;
      ptr_nxt       = ptr;
      idx_nxt       = idx;
      disp_bank_nxt = disp_bank;
      wr_en         = 1'b0;
      if (state == FETCH && MGIA_ACK_I && !LINE_I) begin
         wr_en   = 1'b1;
         ptr_nxt = ptr + PTR_ONE;
         idx_nxt = idx + 6'd1;
         if (idx == LAST_IDX) begin
            state_nxt = IDLE;
         end
      end
      if (LINE_I) begin
         disp_bank_nxt = ~disp_bank;
         if (state == FETCH) begin
            ptr_nxt   = line_base + LINE_STRIDE;
            state_nxt = IDLE;
         end
      end
      if (VSYNC_I) begin
         line_base_nxt = FB_BASE_I;
         ptr_nxt       = FB_BASE_I;
      end
      if (LINE_I && FETCH_EN_I) begin
         line_base_nxt = ptr_nxt;
         idx_nxt       = 6'd0;
         state_nxt     = FETCH;
      end
   end

   always_ff @(posedge CLK_I_25MHZ or negedge RST_N_I) begin
      if (!RST_N_I) begin
         state     <= IDLE;
         line_base <= '0;
         ptr       <= '0;
         idx       <= '0;
         disp_bank <= 1'b0;
      end else begin
         state     <= state_nxt;
         line_base <= line_base_nxt;
         ptr       <= ptr_nxt;
         idx       <= idx_nxt;
         disp_bank <= disp_bank_nxt;
      end
   end

   // Line buffer has no reset; bank select is the MSB of the 7-bit word address.
   always_ff @(posedge CLK_I_25MHZ) begin
      if (wr_en) begin
         line_mem[{~disp_bank, idx}] <= MGIA_DAT_I;
      end
   end

   assign F_DAT_O    = line_mem[{disp_bank, F_ADR_I}];
   assign MGIA_ADR_O = ptr;
   assign MGIA_CYC_O = (state == FETCH);
   assign MGIA_STB_O = (state == FETCH);

`ifdef MGIA_UNDERRUN_EN
   always_ff @(posedge CLK_I_25MHZ or negedge RST_N_I) begin
      if (!RST_N_I) begin
         UNDERRUN_O <= 1'b0;
      end else if (LINE_I && state == FETCH) begin
         UNDERRUN_O <= 1'b1;
      end else if (VSYNC_I) begin
         UNDERRUN_O <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_mgia_line_fetch.sv
// Directed bench for mgia_line_fetch; bus addresses and fetched words are queued as expectations and checked as the DUT produces them.
// Checks UNDERRUN_O as well when MGIA_UNDERRUN_EN is defined.
`timescale 1ns/100ps
module tb_mgia_line_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vsync = 1'b0;
   logic        line = 1'b0;
   logic        fetch_en = 1'b0;
   logic [22:0] fb_base = '0;
   logic [22:0] adr;
   logic        cyc;
   logic        stb;
   logic        ack = 1'b0;
   logic [15:0] dat = '0;
   logic [5:0]  f_adr = '0;
   logic [15:0] f_dat;
`ifdef MGIA_UNDERRUN_EN
   logic        underrun;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] adr_q [$];
   logic [31:0] data_q [$];

   mgia_line_fetch #(.WORDS_PER_LINE(40), .AW(23)) dut (
      .CLK_I_25MHZ (clk),
      .RST_N_I     (rst_n),
      .VSYNC_I     (vsync),
      .LINE_I      (line),
      .FETCH_EN_I  (fetch_en),
      .FB_BASE_I   (fb_base),
      .MGIA_ADR_O  (adr),
      .MGIA_CYC_O  (cyc),
      .MGIA_STB_O  (stb),
      .MGIA_ACK_I  (ack),
      .MGIA_DAT_I  (dat),
      .F_ADR_I     (f_adr),
      .F_DAT_O     (f_dat)
`ifdef MGIA_UNDERRUN_EN
      ,
      .UNDERRUN_O  (underrun)
`endif
   );

   always #20 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse(logic vs, logic ln, logic en, logic [22:0] fb);
      vsync    = vs;
      line     = ln;
      fetch_en = en;
      fb_base  = fb;
      step();
      vsync    = 1'b0;
      line     = 1'b0;
      fetch_en = 1'b0;
   endtask

   task automatic push_adr(logic [22:0] base, int n);
      for (int i = 0; i < n; i++) adr_q.push_back(32'(base) + 32'(i));
   endtask

   // Acks n words with the given number of wait states before each ack.
   task automatic serve(int n, int waits, logic [15:0] dbase);
      for (int i = 0; i < n; i++) begin
         logic [31:0] exp_adr;
         exp_adr = adr_q.pop_front();
         for (int w = 0; w < waits; w++) begin
            chk("stb_wait", 32'(stb), 32'd1);
            chk("adr_wait", 32'(adr), exp_adr);
            step();
         end
         chk("cyc_fetch", 32'(cyc), 32'd1);
         chk("adr_fetch", 32'(adr), exp_adr);
         ack = 1'b1;
         dat = dbase + 16'(i);
         data_q.push_back(32'(dbase) + 32'(i));
         step();
         ack = 1'b0;
      end
   endtask

   task automatic readback(int n);
      for (int i = 0; i < n; i++) begin
         f_adr = 6'(i);
         #0.5;
         chk("rd_data", 32'(f_dat), data_q.pop_front());
      end
   endtask

   initial begin
      // reset state
      step();
      chk("rst_cyc", 32'(cyc), 32'd0);
      chk("rst_stb", 32'(stb), 32'd0);
      chk("rst_adr", 32'(adr), 32'd0);
`ifdef MGIA_UNDERRUN_EN
      chk("rst_underrun", 32'(underrun), 32'd0);
`endif
      rst_n = 1'b1;
      step();

      // line 0x1000..0x1027 into bank 0, ack every cycle
      pulse(1'b1, 1'b0, 1'b0, 23'h1000);
      push_adr(23'h1000, 40);
      pulse(1'b0, 1'b1, 1'b1, 23'h0);
      serve(40, 0, 16'hA000);
      chk("cyc_after_last", 32'(cyc), 32'd0);
      chk("stb_after_last", 32'(stb), 32'd0);

      // swap without fetch; display bank 0 immediately after the pulse
      f_adr = 6'd5;
      pulse(1'b0, 1'b1, 1'b0, 23'h0);
      chk("swap_word5", 32'(f_dat), 32'hA005);
      f_adr = 6'd6;
      #1;
      chk("comb_word6", 32'(f_dat), 32'hA006);
      chk("noen_cyc", 32'(cyc), 32'd0);
      data_q.delete();

      // next line resumes at 0x1028 into bank 1 with 3 wait states
      pulse(1'b0, 1'b1, 1'b0, 23'h0);
      push_adr(23'h1028, 40);
      pulse(1'b0, 1'b1, 1'b1, 23'h0);
      serve(40, 3, 16'hB000);
      chk("ws_cyc_done", 32'(cyc), 32'd0);
      pulse(1'b0, 1'b1, 1'b0, 23'h0);
      readback(40);

      // reset mid-fetch, then an ack in IDLE must not write bank 1
      pulse(1'b0, 1'b1, 1'b1, 23'h0);
      chk("pre_rst_cyc", 32'(cyc), 32'd1);
      chk("pre_rst_adr", 32'(adr), 32'h1050);
      #5;
      rst_n = 1'b0;
      #1;
      chk("async_cyc", 32'(cyc), 32'd0);
      chk("async_stb", 32'(stb), 32'd0);
      chk("async_adr", 32'(adr), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      ack = 1'b1;
      dat = 16'hDEAD;
      step();
      step();
      ack = 1'b0;
      chk("idle_ack_cyc", 32'(cyc), 32'd0);
      f_adr = 6'd0;
      pulse(1'b0, 1'b1, 1'b0, 23'h0);
      chk("idle_ack_nowrite", 32'(f_dat), 32'hB000);

      // abort after 10 words of line 0x2000
      pulse(1'b1, 1'b0, 1'b0, 23'h2000);
      push_adr(23'h2000, 10);
      pulse(1'b0, 1'b1, 1'b1, 23'h0);
      serve(10, 0, 16'hC000);
      chk("abort_pre_adr", 32'(adr), 32'h200A);
      pulse(1'b0, 1'b1, 1'b1, 23'h0);
      chk("abort_cyc", 32'(cyc), 32'd1);
      chk("abort_adr", 32'(adr), 32'h2028);
`ifdef MGIA_UNDERRUN_EN
      chk("underrun_set", 32'(underrun), 32'd1);
`endif
      f_adr = 6'd0;
      #0.5;
      chk("abort_word0", 32'(f_dat), 32'hC000);
      f_adr = 6'd9;
      #0.5;
      chk("abort_word9", 32'(f_dat), 32'hC009);
      f_adr = 6'd10;
      #0.5;
      chk("abort_stale10", 32'(f_dat), 32'hB00A);

      // abort with fetch disabled drops the bus; ptr keeps line alignment
      pulse(1'b0, 1'b1, 1'b0, 23'h0);
      chk("abort_idle_cyc", 32'(cyc), 32'd0);
      chk("abort_idle_stb", 32'(stb), 32'd0);
`ifdef MGIA_UNDERRUN_EN
      chk("underrun_sticky", 32'(underrun), 32'd1);
`endif
      pulse(1'b0, 1'b1, 1'b1, 23'h0);
      chk("aligned_adr", 32'(adr), 32'h2050);

      // VSYNC and LINE together during a fetch: restart at the new base
      pulse(1'b1, 1'b1, 1'b1, 23'h3000);
      chk("vs_line_adr", 32'(adr), 32'h3000);
      chk("vs_line_cyc", 32'(cyc), 32'd1);
`ifdef MGIA_UNDERRUN_EN
      chk("underrun_set_wins", 32'(underrun), 32'd1);
`endif
      pulse(1'b1, 1'b0, 1'b0, 23'h3000);
`ifdef MGIA_UNDERRUN_EN
      chk("underrun_clear", 32'(underrun), 32'd0);
`endif
      data_q.delete();
      push_adr(23'h3000, 40);
      serve(40, 0, 16'hD000);
      chk("final_cyc", 32'(cyc), 32'd0);
      pulse(1'b0, 1'b1, 1'b0, 23'h0);
      readback(40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
